// File: rtl/alk_pkg.sv
// Shared ALK constants: loop counter width default and WBUS flag bit positions.
// No state; compile-time constants only.
// Also used by the downstream ALK WBUS readout mux, so flag bit positions stay consistent.
package alk_pkg;
  localparam int LCNT_W_DEF   = 5;
  localparam int WB_ALUSO_BIT = 31;
  localparam int WB_ALKC_BIT  = 30;
endpackage

// File: rtl/alkloopc.sv
// ALK loop step counter and loop-terminated flag for multiply/divide step sequences.
// Latency: 1 clk from strobe to updated counter/flag; loop_zero is combinational.
// No flow control: strobes are acted on in the cycle they are presented.
module alkloopc
  import alk_pkg::*;
#(
  parameter int CNT_W = LCNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_h,
  input  logic             ld_loopc,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             dec_loopc,
  input  logic             set_loopf,
  input  logic             clr_loopf,
  output logic             loop_flag,
  output logic [CNT_W-1:0] loop_cnt,
  output logic             loop_zero
);

  logic cnt_is_zero;
  logic cnt_is_one;

  assign cnt_is_zero = (loop_cnt == '0);
  assign cnt_is_one  = (loop_cnt == CNT_W'(1));
  assign loop_zero   = cnt_is_zero;

  // Counter: load beats decrement; decrement saturates at zero instead of wrapping.
  always_ff @(posedge clk or posedge reset_h) begin
    if (reset_h) begin
      loop_cnt <= '0;
    end else if (ld_loopc) begin
      loop_cnt <= ld_val;
    end else if (dec_loopc && !cnt_is_zero) begin
      loop_cnt <= loop_cnt - CNT_W'(1);
    end
  end

  // Loop flag: clr > set > load (flag set when loading zero) > terminal/saturated dec.
  always_ff @(posedge clk or posedge reset_h) begin
    if (reset_h) begin
      loop_flag <= 1'b0;
    end else if (clr_loopf) begin
      loop_flag <= 1'b0;
    end else if (set_loopf) begin
      loop_flag <= 1'b1;
    end else if (ld_loopc) begin
      loop_flag <= (ld_val == '0);
    end else if (dec_loopc && (cnt_is_one || cnt_is_zero)) begin
      loop_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/alkflags.sv
// ALK flag/state stage: ALU carry and sign-xor-overflow flags plus loop counter/flag.
// Latency: 1 clk from strobe to registered output; loop_zero_h is combinational.
// No flow control: every strobe is accepted in the cycle it is asserted.
module alkflags
  import alk_pkg::*;
#(
  parameter int LCNT_W = LCNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_h,
  input  logic              alpctl_ld_aluf_h,
  input  logic              alu_c_h,
  input  logic              alu_n_h,
  input  logic              alu_v_h,
  input  logic              alpctl_wb_ldf_h,
  input  logic [31:0]       wbus_in_h,
  input  logic              alpctl_ld_loopc_h,
  input  logic              alpctl_dec_loopc_h,
  input  logic              alpctl_set_loopf_h,
  input  logic              alpctl_clr_loopf_h,
  output logic              alkc_flag_h,
  output logic              aluso_flag_h,
  output logic              loop_flag_h,
  output logic [LCNT_W-1:0] loop_cnt_h,
  output logic              loop_zero_h
);

  // Flag capture: a WBUS restore takes precedence over a live ALU capture.
  always_ff @(posedge clk or posedge reset_h) begin
    if (reset_h) begin
      alkc_flag_h  <= 1'b0;
      aluso_flag_h <= 1'b0;
    end else if (alpctl_wb_ldf_h) begin
      alkc_flag_h  <= wbus_in_h[WB_ALKC_BIT];
      aluso_flag_h <= wbus_in_h[WB_ALUSO_BIT];
    end else if (alpctl_ld_aluf_h) begin
      alkc_flag_h  <= alu_c_h;
      aluso_flag_h <= alu_n_h ^ alu_v_h;
    end
  end

  alkloopc #(
    .CNT_W (LCNT_W)
  ) u_loopc (
    .clk       (clk),
    .reset_h   (reset_h),
    .ld_loopc  (alpctl_ld_loopc_h),
    .ld_val    (wbus_in_h[LCNT_W-1:0]),
    .dec_loopc (alpctl_dec_loopc_h),
    .set_loopf (alpctl_set_loopf_h),
    .clr_loopf (alpctl_clr_loopf_h),
    .loop_flag (loop_flag_h),
    .loop_cnt  (loop_cnt_h),
    .loop_zero (loop_zero_h)
  );

endmodule

// File: tb/tb_alkflags.sv
// Self-checking bench for alkflags: directed scenarios then randomized strobes
// compared against an integer-level behavioural model of the flag and loop rules.
module tb_alkflags;

  localparam int W = 5;

  logic          clk = 1'b0;
  logic          reset_h;
  logic          ld_aluf, alu_c, alu_n, alu_v, wb_ldf;
  logic [31:0]   wbus;
  logic          ld_loopc, dec_loopc, set_loopf, clr_loopf;
  logic          alkc, aluso, loop_flag, loop_zero;
  logic [W-1:0]  loop_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_c, m_so, m_flag, m_cnt;

  always #5 clk = ~clk;

  alkflags #(.LCNT_W(W)) dut (
    .clk                (clk),
    .reset_h            (reset_h),
    .alpctl_ld_aluf_h   (ld_aluf),
    .alu_c_h            (alu_c),
    .alu_n_h            (alu_n),
    .alu_v_h            (alu_v),
    .alpctl_wb_ldf_h    (wb_ldf),
    .wbus_in_h          (wbus),
    .alpctl_ld_loopc_h  (ld_loopc),
    .alpctl_dec_loopc_h (dec_loopc),
    .alpctl_set_loopf_h (set_loopf),
    .alpctl_clr_loopf_h (clr_loopf),
    .alkc_flag_h        (alkc),
    .aluso_flag_h       (aluso),
    .loop_flag_h        (loop_flag),
    .loop_cnt_h         (loop_cnt),
    .loop_zero_h        (loop_zero)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_strobes();
    ld_aluf = 0; alu_c = 0; alu_n = 0; alu_v = 0; wb_ldf = 0; wbus = '0;
    ld_loopc = 0; dec_loopc = 0; set_loopf = 0; clr_loopf = 0;
  endtask

  task automatic model_reset();
    m_c = 0; m_so = 0; m_flag = 0; m_cnt = 0;
  endtask

  // Apply the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    int ldv;
    int old_cnt;
    ldv = int'(wbus) & ((1 << W) - 1);
    old_cnt = m_cnt;
    if (wb_ldf) begin
      m_so = int'(wbus[31]); m_c = int'(wbus[30]);
    end else if (ld_aluf) begin
      m_c = int'(alu_c); m_so = int'(alu_n ^ alu_v);
    end
    if (ld_loopc) m_cnt = ldv;
    else if (dec_loopc) m_cnt = (old_cnt > 0) ? old_cnt - 1 : 0;
    if (clr_loopf) m_flag = 0;
    else if (set_loopf) m_flag = 1;
    else if (ld_loopc) m_flag = (ldv == 0) ? 1 : 0;
    else if (dec_loopc && old_cnt <= 1) m_flag = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".alkc"}, int'(alkc), m_c);
    chk({tag, ".aluso"}, int'(aluso), m_so);
    chk({tag, ".loopf"}, int'(loop_flag), m_flag);
    chk({tag, ".cnt"}, int'(loop_cnt), m_cnt);
    chk({tag, ".zero"}, int'(loop_zero), (m_cnt == 0) ? 1 : 0);
  endtask

  // One clock: inputs were set after a negedge; model follows the posedge,
  // outputs are compared at the following negedge, then strobes are dropped.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
    clear_strobes();
  endtask

  initial begin
    clear_strobes();
    reset_h = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("reset");
    reset_h = 1'b0;

    // Scenario 2: ALU capture then WBUS restore
    ld_aluf = 1; alu_c = 1; alu_n = 1; alu_v = 1;
    tick("aluf");
    chk("aluf_c", int'(alkc), 1);
    chk("aluf_so", int'(aluso), 0);
    wb_ldf = 1; wbus = 32'h8000_0000;
    tick("wbldf");
    chk("wbldf_c", int'(alkc), 0);
    chk("wbldf_so", int'(aluso), 1);

    // Scenario 3: load 3, step down, saturate
    ld_loopc = 1; wbus = 32'd3;
    tick("ld3");
    chk("ld3_cnt", int'(loop_cnt), 3);
    for (int i = 0; i < 4; i++) begin
      dec_loopc = 1;
      tick("dec");
      chk("dec_cnt", int'(loop_cnt), (i < 3) ? 2 - i : 0);
      chk("dec_flag", int'(loop_flag), (i >= 2) ? 1 : 0);
    end

    // Scenario 4: load zero; load with simultaneous dec
    ld_loopc = 1; wbus = 32'd0;
    tick("ld0");
    chk("ld0_flag", int'(loop_flag), 1);
    ld_loopc = 1; dec_loopc = 1; wbus = 32'd7;
    tick("ld7dec");
    chk("ld7dec_cnt", int'(loop_cnt), 7);
    chk("ld7dec_flag", int'(loop_flag), 0);

    // Scenario 5: clr beats set; set alone leaves counter alone
    set_loopf = 1; clr_loopf = 1;
    tick("setclr");
    chk("setclr_flag", int'(loop_flag), 0);
    set_loopf = 1;
    tick("set");
    chk("set_flag", int'(loop_flag), 1);
    chk("set_cnt", int'(loop_cnt), 7);

    // Scenario 6: WBUS restore beats ALU capture
    wb_ldf = 1; wbus = 32'h4000_0000; ld_aluf = 1; alu_c = 0; alu_n = 1; alu_v = 0;
    tick("wbprio");
    chk("wbprio_c", int'(alkc), 1);
    chk("wbprio_so", int'(aluso), 0);

    // Scenario 1: async reset mid-loop with everything set
    ld_loopc = 1; wb_ldf = 1; wbus = 32'hC000_0005;
    tick("preload");
    set_loopf = 1;
    tick("preset");
    chk("pre_cnt", int'(loop_cnt), 5);
    chk("pre_flag", int'(loop_flag), 1);
    #2 reset_h = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset_h = 1'b0;

    // Randomized traffic with biased strobes
    for (int n = 0; n < 400; n++) begin
      ld_aluf   = ($urandom_range(0, 3) == 0);
      alu_c     = 1'($urandom);
      alu_n     = 1'($urandom);
      alu_v     = 1'($urandom);
      wb_ldf    = ($urandom_range(0, 5) == 0);
      wbus      = $urandom;
      if ($urandom_range(0, 1) == 0) wbus[W-1:0] = W'($urandom_range(0, 3));
      ld_loopc  = ($urandom_range(0, 7) == 0);
      dec_loopc = ($urandom_range(0, 1) == 0);
      set_loopf = ($urandom_range(0, 11) == 0);
      clr_loopf = ($urandom_range(0, 11) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
